// File: rtl/localbus_xbar_pkg.sv
// Shared constants and types for the local-bus crossbar: FSM encoding,
// write-enable width and the timeout counter width.
package localbus_xbar_pkg;

   localparam int         WE_W    = 3;
   localparam int         TOUT_W  = 8;
   localparam logic [2:0] WE_NONE = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

endpackage

// File: rtl/localbus_xbar_if.sv
// Local-bus bundle: core-side request/response plus the packed slave channels.
interface localbus_xbar_if
   import localbus_xbar_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NSLV = 4
) ();

   logic                  m_req;
   logic [XLEN-1:0]       m_addr;
   logic [XLEN-1:0]       m_wdata;
   logic [WE_W-1:0]       m_we;
   logic [XLEN-1:0]       m_rdata;
   logic                  m_ready;
   logic                  m_err;
   logic [NSLV-1:0]       s_sel;
   logic [XLEN-1:0]       s_addr;
   logic [XLEN-1:0]       s_wdata;
   logic [WE_W-1:0]       s_we;
   logic [NSLV*XLEN-1:0]  s_rdata;
   logic [NSLV-1:0]       s_ready;

   modport xbar (
      input  m_req, m_addr, m_wdata, m_we, s_rdata, s_ready,
      output m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_we
   );

   modport master (
      output m_req, m_addr, m_wdata, m_we,
      input  m_rdata, m_ready, m_err
   );

   modport slave (
      input  s_sel, s_addr, s_wdata, s_we,
      output s_rdata, s_ready
   );

endinterface

// File: rtl/localbus_xbar_dec.sv
// Combinational base/mask address decoder: one-hot hit with lowest-index
// priority, a miss flag, and the offset of the address inside the winning window.
module lbus_addr_decoder
   import localbus_xbar_pkg::*;
#(
   parameter int                   XLEN     = 32,
   parameter int                   NSLV     = 4,
   parameter logic [NSLV*XLEN-1:0] SLV_BASE = '0,
   parameter logic [NSLV*XLEN-1:0] SLV_MASK = '0
) (
   input  logic [XLEN-1:0] i_addr,
   output logic [NSLV-1:0] o_hit,
   output logic            o_miss,
   output logic [XLEN-1:0] o_offset
);

   logic [XLEN-1:0] w_base;
   logic            w_found;

   always_comb begin
      o_hit   = '0;
      w_base  = '0;
      w_found = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (!w_found &&
             ((i_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN])) begin
            o_hit[i] = 1'b1;
            w_base   = SLV_BASE[i*XLEN +: XLEN];
            w_found  = 1'b1;
         end
      end
   end

   assign o_miss   = ~w_found;
   assign o_offset = i_addr - w_base;

endmodule

// File: rtl/localbus_xbar.sv
// Local-bus crossbar: one master to NSLV slaves with req/ready handshake,
// wait states, registered read return, unmapped-address error and access timeout.
module localbus_xbar
   import localbus_xbar_pkg::*;
#(
   parameter int                   XLEN     = 32,
   parameter int                   NSLV     = 4,
   parameter logic [NSLV*XLEN-1:0] SLV_BASE = '0,
   parameter logic [NSLV*XLEN-1:0] SLV_MASK = '0,
   parameter int                   TOUT     = 15
) (
   input  logic            clk,
   input  logic            rst,
   localbus_xbar_if.xbar   bus
);

   localparam logic [TOUT_W-1:0] TOUT_CNT = TOUT_W'(TOUT);

   state_t              r_state;
   logic [NSLV-1:0]     r_sel;
   logic [XLEN-1:0]     r_addr;
   logic [XLEN-1:0]     r_wdata;
   logic [WE_W-1:0]     r_we;
   logic [XLEN-1:0]     r_rdata;
   logic                r_ready;
   logic                r_err;
   logic [TOUT_W-1:0]   r_tout_cnt;

   logic [NSLV-1:0]     w_hit;
   logic                w_miss;
   logic [XLEN-1:0]     w_offset;
   logic                w_sel_ready;
   logic [XLEN-1:0]     w_rdata_mux;

   lbus_addr_decoder #(
      .XLEN     (XLEN),
      .NSLV     (NSLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .i_addr   (bus.m_addr),
      .o_hit    (w_hit),
      .o_miss   (w_miss),
      .o_offset (w_offset)
   );

   // r_sel is one-hot, so OR-ing the gated channels is a plain mux
   always_comb begin
      w_rdata_mux = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (r_sel[i]) begin
            w_rdata_mux = w_rdata_mux | bus.s_rdata[i*XLEN +: XLEN];
         end
      end
   end

   assign w_sel_ready = |(r_sel & bus.s_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= WE_NONE;
         r_rdata    <= '0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
         r_tout_cnt <= '0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         case (r_state)
            ST_IDLE: begin
               if (bus.m_req) begin
                  if (w_miss) begin
                     r_state <= ST_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state    <= ST_ACCESS;
                     r_sel      <= w_hit;
                     r_addr     <= w_offset;
                     r_wdata    <= bus.m_wdata;
                     r_we       <= bus.m_we;
                     r_tout_cnt <= '0;
                  end
               end
            end
            ST_ACCESS: begin
               // a ready arriving on the last allowed cycle still wins over the timeout
               if (w_sel_ready) begin
                  r_state <= ST_DONE;
                  r_ready <= 1'b1;
                  r_sel   <= '0;
                  r_we    <= WE_NONE;
                  if (r_we == WE_NONE) begin
                     r_rdata <= w_rdata_mux;
                  end
               end else if (r_tout_cnt == TOUT_CNT) begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
                  r_sel   <= '0;
                  r_we    <= WE_NONE;
               end else begin
                  r_tout_cnt <= r_tout_cnt + 1'b1;
               end
            end
            ST_DONE, ST_ERR: r_state <= ST_IDLE;
            default:         r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.s_sel   = r_sel;
   assign bus.s_addr  = r_addr;
   assign bus.s_wdata = r_wdata;
   assign bus.s_we    = r_we;
   assign bus.m_rdata = r_rdata;
   assign bus.m_ready = r_ready;
   assign bus.m_err   = r_err;

endmodule
